// File: rtl/wfg_pat_seq.sv
// Pattern sequencer: streams a programmable address window of a local pattern RAM
// over AXI-stream, repeating the window for a programmed number of passes.
module wfg_pat_seq #(
    parameter  int DEPTH      = 16,
    parameter  int AXIS_WIDTH = 32,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_en_q_i,
    input  logic [ADDR_W-1:0]     cfg_start_addr_q_i,
    input  logic [ADDR_W-1:0]     cfg_end_addr_q_i,
    input  logic [7:0]            cfg_loop_cnt_q_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_W-1:0]     mem_waddr_i,
    input  logic [AXIS_WIDTH-1:0] mem_wdata_i,
    input  logic                  wfg_axis_tready_i,
    output logic                  wfg_axis_tvalid_o,
    output logic                  wfg_axis_tlast_o,
    output logic [AXIS_WIDTH-1:0] wfg_axis_tdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [7:0]            pass_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                state_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [ADDR_W-1:0]     start_reg;
    logic [ADDR_W-1:0]     end_reg;
    logic [7:0]            loop_reg;
    logic [7:0]            pass_reg;
    logic                  tvalid_reg;
    logic                  tlast_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [AXIS_WIDTH-1:0] rd_data_reg;
    logic [AXIS_WIDTH-1:0] mem [DEPTH];

    logic       at_end;
    logic       handshake;
    logic [7:0] pass_inc;

    assign at_end    = (addr_reg == end_reg);
    assign handshake = tvalid_reg && wfg_axis_tready_i;
    assign pass_inc  = pass_reg + 8'd1;

    // Pattern RAM: no reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we_i) begin
            mem[mem_waddr_i] <= mem_wdata_i;
        end
    end

    // Read only in FETCH, so the word stays stable for the whole SEND state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (state_reg == ST_FETCH && ctrl_en_q_i) begin
            rd_data_reg <= mem[addr_reg];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= '0;
            start_reg  <= '0;
            end_reg    <= '0;
            loop_reg   <= '0;
            pass_reg   <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ctrl_en_q_i) begin
                        start_reg <= cfg_start_addr_q_i;
                        end_reg   <= cfg_end_addr_q_i;
                        loop_reg  <= cfg_loop_cnt_q_i;
                        addr_reg  <= cfg_start_addr_q_i;
                        pass_reg  <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!ctrl_en_q_i) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        tvalid_reg <= 1'b1;
                        tlast_reg  <= at_end;
                        state_reg  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Enable is only sampled on a completed beat, never withdrawing tvalid.
                    if (handshake) begin
                        tvalid_reg <= 1'b0;
                        tlast_reg  <= 1'b0;
                        if (at_end && loop_reg != 8'd0 && pass_inc == loop_reg) begin
                            pass_reg  <= pass_inc;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_DONE;
                        end else if (!ctrl_en_q_i) begin
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else if (at_end) begin
                            if (pass_reg != 8'hFF) begin
                                pass_reg <= pass_inc;
                            end
                            addr_reg  <= start_reg;
                            state_reg <= ST_FETCH;
                        end else begin
                            addr_reg  <= addr_reg + 1'b1;
                            state_reg <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    if (!ctrl_en_q_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign wfg_axis_tvalid_o = tvalid_reg;
    assign wfg_axis_tlast_o  = tlast_reg;
    assign wfg_axis_tdata_o  = rd_data_reg;
    assign busy_o            = busy_reg;
    assign done_o            = done_reg;
    assign pass_cnt_o        = pass_reg;

endmodule

// File: tb/tb_wfg_pat_seq.sv
// Directed bench for wfg_pat_seq: ordered beats, wrap window, backpressure,
// abort, writes during a run and asynchronous reset mid-run.
module tb_wfg_pat_seq;

    logic        clk;
    logic        rst_n;
    logic        ctrl_en_q_i;
    logic [3:0]  cfg_start_addr_q_i;
    logic [3:0]  cfg_end_addr_q_i;
    logic [7:0]  cfg_loop_cnt_q_i;
    logic        mem_we_i;
    logic [3:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        wfg_axis_tready_i;
    logic        wfg_axis_tvalid_o;
    logic        wfg_axis_tlast_o;
    logic [31:0] wfg_axis_tdata_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  pass_cnt_o;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;
    int done_cnt = 0;

    wfg_pat_seq #(.DEPTH(16), .AXIS_WIDTH(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ctrl_en_q_i        (ctrl_en_q_i),
        .cfg_start_addr_q_i (cfg_start_addr_q_i),
        .cfg_end_addr_q_i   (cfg_end_addr_q_i),
        .cfg_loop_cnt_q_i   (cfg_loop_cnt_q_i),
        .mem_we_i           (mem_we_i),
        .mem_waddr_i        (mem_waddr_i),
        .mem_wdata_i        (mem_wdata_i),
        .wfg_axis_tready_i  (wfg_axis_tready_i),
        .wfg_axis_tvalid_o  (wfg_axis_tvalid_o),
        .wfg_axis_tlast_o   (wfg_axis_tlast_o),
        .wfg_axis_tdata_o   (wfg_axis_tdata_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .pass_cnt_o         (pass_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_o) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [3:0] a, input logic [31:0] d);
        mem_we_i    = 1'b1;
        mem_waddr_i = a;
        mem_wdata_i = d;
        step();
        mem_we_i    = 1'b0;
    endtask

    // Captures the next accepted beat and returns just after its handshake edge.
    task automatic wait_beat(input string tag, output logic [31:0] d, output logic l, output int c);
        logic found;
        found = 1'b0;
        d = '0;
        l = 1'b0;
        c = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (wfg_axis_tvalid_o && wfg_axis_tready_i) begin
                d = wfg_axis_tdata_o;
                l = wfg_axis_tlast_o;
                c = cyc;
                found = 1'b1;
            end
            step();
        end
        check({tag, "_beat_seen"}, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50 && !wfg_axis_tvalid_o; i++) step();
        check({tag, "_valid_seen"}, {31'd0, wfg_axis_tvalid_o}, 32'd1);
    endtask

    task automatic set_cfg(input logic [3:0] s, input logic [3:0] e, input logic [7:0] n);
        cfg_start_addr_q_i = s;
        cfg_end_addr_q_i   = e;
        cfg_loop_cnt_q_i   = n;
    endtask

    task automatic stop_run();
        ctrl_en_q_i = 1'b0;
        step();
        step();
    endtask

    logic [31:0] d;
    logic        l;
    int          c;
    int          prev_c;
    int          done_base;
    logic        saw_valid;
    logic [31:0] exp_t1 [4];
    logic [31:0] exp_t2 [4];

    initial begin
        rst_n = 1'b0;
        ctrl_en_q_i = 1'b0;
        mem_we_i = 1'b0;
        mem_waddr_i = '0;
        mem_wdata_i = '0;
        wfg_axis_tready_i = 1'b0;
        set_cfg(4'd0, 4'd0, 8'd0);
        exp_t1 = '{32'hA5, 32'h5A, 32'hFF, 32'h00};
        exp_t2 = '{32'h140, 32'h150, 32'h100, 32'h110};
        prev_c = 0;

        step();
        step();
        check("rst_tvalid", {31'd0, wfg_axis_tvalid_o}, 32'd0);
        check("rst_tlast", {31'd0, wfg_axis_tlast_o}, 32'd0);
        check("rst_tdata", wfg_axis_tdata_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_pass", {24'd0, pass_cnt_o}, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic ordered run, one pass
        for (int i = 0; i < 4; i++) mem_write(4'(i), exp_t1[i]);
        set_cfg(4'd0, 4'd3, 8'd1);
        wfg_axis_tready_i = 1'b1;
        done_base = done_cnt;
        ctrl_en_q_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_beat("t1", d, l, c);
            check("t1_data", d, exp_t1[i]);
            check("t1_last", {31'd0, l}, (i == 3) ? 32'd1 : 32'd0);
            if (i > 0) check("t1_spacing", c - prev_c, 32'd2);
            if (i == 0) check("t1_pass_start", {24'd0, pass_cnt_o}, 32'd0);
            prev_c = c;
        end
        check("t1_done_pulse", {31'd0, done_o}, 32'd1);
        check("t1_pass", {24'd0, pass_cnt_o}, 32'd1);
        check("t1_busy_done", {31'd0, busy_o}, 32'd0);
        step();
        check("t1_done_clear", {31'd0, done_o}, 32'd0);
        step();
        step();
        check("t1_hold_tvalid", {31'd0, wfg_axis_tvalid_o}, 32'd0);
        check("t1_hold_busy", {31'd0, busy_o}, 32'd0);
        check("t1_done_count", done_cnt - done_base, 32'd1);
        stop_run();
        check("t1_pass_idle", {24'd0, pass_cnt_o}, 32'd1);

        // Wrapped window 14,15,0,1 for two passes
        for (int i = 0; i < 4; i++) mem_write(4'(14 + i), exp_t2[i]);
        set_cfg(4'd14, 4'd1, 8'd2);
        done_base = done_cnt;
        ctrl_en_q_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_beat("t2", d, l, c);
            check("t2_data", d, exp_t2[i % 4]);
            check("t2_last", {31'd0, l}, (i % 4 == 3) ? 32'd1 : 32'd0);
            if (i == 3) check("t2_pass_mid", {24'd0, pass_cnt_o}, 32'd1);
        end
        check("t2_done_pulse", {31'd0, done_o}, 32'd1);
        check("t2_pass", {24'd0, pass_cnt_o}, 32'd2);
        stop_run();
        check("t2_done_count", done_cnt - done_base, 32'd1);

        // Backpressure on addresses 2..3
        set_cfg(4'd2, 4'd3, 8'd1);
        wfg_axis_tready_i = 1'b0;
        ctrl_en_q_i = 1'b1;
        wait_valid("t3");
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_data", wfg_axis_tdata_o, 32'hFF);
            check("t3_hold_last", {31'd0, wfg_axis_tlast_o}, 32'd0);
            check("t3_hold_valid", {31'd0, wfg_axis_tvalid_o}, 32'd1);
            step();
        end
        wfg_axis_tready_i = 1'b1;
        wait_beat("t3", d, l, c);
        check("t3_data0", d, 32'hFF);
        check("t3_last0", {31'd0, l}, 32'd0);
        wait_beat("t3", d, l, c);
        check("t3_data1", d, 32'h00);
        check("t3_last1", {31'd0, l}, 32'd1);
        check("t3_done", {31'd0, done_o}, 32'd1);
        stop_run();

        // Abort during SEND with backpressure, infinite loop mode
        set_cfg(4'd0, 4'd1, 8'd0);
        wfg_axis_tready_i = 1'b0;
        done_base = done_cnt;
        ctrl_en_q_i = 1'b1;
        wait_valid("t4");
        ctrl_en_q_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_held_valid", {31'd0, wfg_axis_tvalid_o}, 32'd1);
            check("t4_held_data", wfg_axis_tdata_o, 32'h100);
        end
        wfg_axis_tready_i = 1'b1;
        step();
        check("t4_abort_valid", {31'd0, wfg_axis_tvalid_o}, 32'd0);
        check("t4_abort_busy", {31'd0, busy_o}, 32'd0);
        check("t4_abort_pass", {24'd0, pass_cnt_o}, 32'd0);
        step();
        check("t4_no_done", done_cnt - done_base, 32'd0);
        check("t4_idle_valid", {31'd0, wfg_axis_tvalid_o}, 32'd0);

        // Abort during FETCH
        ctrl_en_q_i = 1'b1;
        step();
        check("t4_fetch_busy", {31'd0, busy_o}, 32'd1);
        ctrl_en_q_i = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            saw_valid = saw_valid | wfg_axis_tvalid_o;
        end
        check("t4_fetch_no_valid", {31'd0, saw_valid}, 32'd0);
        check("t4_fetch_idle_busy", {31'd0, busy_o}, 32'd0);

        // Write into the window while its beat is held
        mem_write(4'd0, 32'h11);
        set_cfg(4'd0, 4'd0, 8'd3);
        wfg_axis_tready_i = 1'b0;
        ctrl_en_q_i = 1'b1;
        wait_valid("t5a");
        mem_write(4'd0, 32'h22);
        wfg_axis_tready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_beat("t5a", d, l, c);
            check("t5a_data", d, (i == 0) ? 32'h11 : 32'h22);
            check("t5a_last", {31'd0, l}, 32'd1);
        end
        check("t5a_done", {31'd0, done_o}, 32'd1);
        check("t5a_pass", {24'd0, pass_cnt_o}, 32'd3);
        stop_run();

        // Write colliding with the FETCH read returns old data
        mem_write(4'd0, 32'h11);
        ctrl_en_q_i = 1'b1;
        wait_beat("t5b", d, l, c);
        check("t5b_data0", d, 32'h11);
        check("t5b_in_fetch", {30'd0, busy_o, wfg_axis_tvalid_o}, 32'd2);
        mem_we_i    = 1'b1;
        mem_waddr_i = 4'd0;
        mem_wdata_i = 32'h22;
        step();
        mem_we_i = 1'b0;
        wait_beat("t5b", d, l, c);
        check("t5b_data1_old", d, 32'h11);
        wait_beat("t5b", d, l, c);
        check("t5b_data2_new", d, 32'h22);
        check("t5b_done", {31'd0, done_o}, 32'd1);
        stop_run();

        // Async reset mid-SEND after a few infinite-mode passes
        mem_write(4'd2, 32'hFF);
        set_cfg(4'd2, 4'd2, 8'd0);
        ctrl_en_q_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_beat("t6", d, l, c);
            check("t6_data", d, 32'hFF);
        end
        check("t6_pass_inf", {24'd0, pass_cnt_o}, 32'd3);
        wfg_axis_tready_i = 1'b0;
        wait_valid("t6");
        check("t6_busy_pre", {31'd0, busy_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, wfg_axis_tvalid_o}, 32'd0);
        check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t6_rst_pass", {24'd0, pass_cnt_o}, 32'd0);
        check("t6_rst_last", {31'd0, wfg_axis_tlast_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wfg_axis_tready_i = 1'b1;
        wait_beat("t6_rerun", d, l, c);
        check("t6_rerun_data", d, 32'hFF);
        check("t6_rerun_last", {31'd0, l}, 32'd1);
        check("t6_rerun_pass", {24'd0, pass_cnt_o}, 32'd1);
        stop_run();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
